data_cache: RTL and testbench
=============================

# data_cache

Direct-mapped, write-back, write-allocate data cache in the MEM stage of the RV32IM pipeline. It consumes the 4-bit `READ_WRITE` memory command issued by the decode stage and carried down the pipeline, together with the ALU address and the rs2 store data. It performs byte, half and word loads (sign- or zero-extended) and stores. Misses are serviced from a 128-bit block memory, and the pipeline is stalled through `BUSYWAIT` while that happens.

## Interface
- `INDEX_BITS`, default 3: line index width; 2^INDEX_BITS lines of 4 words each.
- `CLK` input 1: clock; all state updates on rising edge.
- `RESET_N` input 1: asynchronous, active-low reset.
- `READ_WRITE` input 4: memory command. Bit 3 = access. 1000 LB, 1001 LH, 1010 LW, 1100 LBU, 1101 LHU, 1011 SB, 1110 SH, 1111 SW. 0xxx = no access.
- `ADDRESS` input 32: byte address from the ALU.
- `WRITE_DATA` input 32: store data (rs2).
- `READ_DATA` output 32: extended load result.
- `BUSYWAIT` output 1: stall request to the pipeline.
- `MEM_READ`, `MEM_WRITE` output 1 each: block memory requests.
- `MEM_ADDRESS` output 28: block address {tag, index}.
- `MEM_WRITEDATA` output 128: evicted block.
- `MEM_READDATA` input 128: fetched block.
- `MEM_BUSYWAIT` input 1: block memory busy.

## Operation
- Address split: tag = `ADDRESS[31:4+INDEX_BITS]`, index = `ADDRESS[3+INDEX_BITS:4]`, word = `ADDRESS[3:2]`, byte = `ADDRESS[1:0]`.
- Per line: valid, dirty, tag, 128-bit data.
- Hit = access && valid && tag match.
- Loads:
  - LB/LBU select the byte at `ADDRESS[1:0]`.
  - LH/LHU select the half at `ADDRESS[1]`.
  - LW selects the whole word.
  - LB and LH sign-extend; LBU and LHU zero-extend.
  - `READ_DATA` is 0 when the command is not a load hit.
- Stores:
  - SB writes the lane at `ADDRESS[1:0]`; SH writes the lane at `ADDRESS[1]`; SW writes the full word.
  - Other bytes are preserved.
  - A store sets dirty.
- FSM states: IDLE, WRITE_BACK, FETCH, UPDATE.
  - IDLE: on access and miss, go to WRITE_BACK if the line is valid and dirty, else to FETCH.
  - WRITE_BACK: `MEM_WRITE`=1, `MEM_ADDRESS`={old tag, index}, `MEM_WRITEDATA`=line data. When `MEM_BUSYWAIT`=0, go to FETCH.
  - FETCH: `MEM_READ`=1, `MEM_ADDRESS`={new tag, index}. When `MEM_BUSYWAIT`=0, go to UPDATE.
  - UPDATE: write `MEM_READDATA` into the line, set valid=1 and dirty=0 and the new tag, then go to IDLE. The access then hits and completes normally; a store sets dirty at that point.
- `BUSYWAIT` is 1 when an access misses in IDLE, and in every non-IDLE state. It is 0 otherwise.
- The pipeline holds `READ_WRITE`, `ADDRESS` and `WRITE_DATA` stable while `BUSYWAIT`=1. Changes to these inputs while busy are not honoured.

## Timing
- Reset (async, immediate):
  - State = IDLE; all valid and dirty bits cleared.
  - `MEM_READ`=`MEM_WRITE`=0, `MEM_ADDRESS`=0, `MEM_WRITEDATA`=0.
  - `BUSYWAIT`=0, `READ_DATA`=0.
- Reset mid-miss: requests drop at once and dirty data is discarded. The pipeline is reset at the same time.
- Hits:
  - Load hit: `READ_DATA` is valid combinationally in the same cycle, with zero stall.
  - Store hit: data is written at the rising edge that ends the cycle.
- Misses:
  - `BUSYWAIT` rises combinationally in the miss cycle.
  - Clean miss: stall = 1 (IDLE) + fetch cycles + 1 (UPDATE). The hit completes in the cycle after UPDATE, with `BUSYWAIT`=0.
  - Dirty miss: additionally includes the write-back cycles.
- Memory requests are registered from state, so they are glitch-free, and they are held until `MEM_BUSYWAIT` falls.
- Back-to-back accesses to the same line after a refill hit with no stall.

## Configuration
- `DCACHE_MISALIGN_CHECK_EN` defined:
  - Adds output `MISALIGNED` (1 bit).
  - A half access with `ADDRESS[0]`=1, or a word access with `ADDRESS[1:0]`≠0, asserts `MISALIGNED` combinationally.
  - Such an access is suppressed: no state change, no stall, `READ_DATA`=0.
  - `MISALIGNED` is 0 at reset.
- Not defined:
  - No `MISALIGNED` port.
  - Low address bits below the access size are ignored, which forces natural alignment.

## Structure
- Shared package `mem_pkg`:
  - `READ_WRITE` encoding constants: MEM_LB, MEM_LH, MEM_LW, MEM_LBU, MEM_LHU, MEM_SB, MEM_SH, MEM_SW.
  - FSM state constants.
  - Block width (128) and word offset width (2).
- One sub-module, `load_store_align`:
  - Combinational.
  - Performs lane select and extension for loads.
  - Performs byte-merge for stores.

## Test plan
- Reset, then LW at 0x0000_0010 → `BUSYWAIT`=1. Fetch sequence occurs: `MEM_READ`=1 with `MEM_ADDRESS`=0x0000001. After refill, `READ_DATA` equals word 0 of the fetched block.
- After that refill, SB of 0x000000A5 at 0x0000_0013, then LB at 0x13 → `READ_DATA`=0xFFFFFFA5. LBU at 0x13 → 0x000000A5. No stalls.
- SH of 0x8001 at 0x12, then LH at 0x12 → 0xFFFF8001 and LHU at 0x12 → 0x00008001. Bytes 0x10–0x11 are unchanged.
- Access to a conflicting tag on the same (dirty) index → WRITE_BACK, with `MEM_WRITE`=1 and `MEM_ADDRESS`=0x0000001 carrying the modified block. FETCH, UPDATE and the hit follow. Stall length is checked with a 3-cycle memory latency.
- Assert `RESET_N`=0 during FETCH → `MEM_READ` and `BUSYWAIT` drop immediately. A following LW at 0x10 misses again.
- `DCACHE_MISALIGN_CHECK_EN` build: LW at 0x0000_0012 → `MISALIGNED`=1, `BUSYWAIT`=0, line unchanged.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared memory-command encodings, data-cache FSM states and block geometry.
// Pure declarations: no latency, no backpressure.
package mem_pkg;

   localparam logic [3:0] MEM_LB  = 4'b1000;
   localparam logic [3:0] MEM_LH  = 4'b1001;
   localparam logic [3:0] MEM_LW  = 4'b1010;
   localparam logic [3:0] MEM_SB  = 4'b1011;
   localparam logic [3:0] MEM_LBU = 4'b1100;
   localparam logic [3:0] MEM_LHU = 4'b1101;
   localparam logic [3:0] MEM_SH  = 4'b1110;
   localparam logic [3:0] MEM_SW  = 4'b1111;

   localparam int BLOCK_W    = 128;
   localparam int WORD_OFF_W = 2;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WRITE_BACK,
      ST_FETCH,
      ST_UPDATE
   } dc_state_t;

   function automatic logic is_store(input logic [3:0] cmd);
      return (cmd == MEM_SB) || (cmd == MEM_SH) || (cmd == MEM_SW);
   endfunction

endpackage

// File: rtl/load_store_align.sv
// Lane select / sign-zero extension for loads and byte-merge for stores.
// Purely combinational: zero latency, no backpressure.
module load_store_align
   import mem_pkg::*;
(
   input  logic [3:0]  cmd,
   input  logic [1:0]  byte_off,
   input  logic [31:0] line_word,
   input  logic [31:0] store_data,
   output logic [31:0] load_data,
   output logic [31:0] merged_word
);

   logic [7:0]  lane_b;
   logic [15:0] lane_h;

   always_comb begin
      lane_b = line_word[{byte_off, 3'b000} +: 8];
      lane_h = byte_off[1] ? line_word[31:16] : line_word[15:0];

      load_data = '0;
      case (cmd)
         MEM_LB:  load_data = {{24{lane_b[7]}}, lane_b};
         MEM_LBU: load_data = {24'b0, lane_b};
         MEM_LH:  load_data = {{16{lane_h[15]}}, lane_h};
         MEM_LHU: load_data = {16'b0, lane_h};
         MEM_LW:  load_data = line_word;
         default: load_data = '0;
      endcase
   end

   // Lanes not covered by the store keep the current line contents.
   always_comb begin
      merged_word = line_word;
      case (cmd)
         MEM_SB: merged_word[{byte_off, 3'b000} +: 8] = store_data[7:0];
         MEM_SH: begin
            if (byte_off[1]) merged_word[31:16] = store_data[15:0];
            else             merged_word[15:0]  = store_data[15:0];
         end
         MEM_SW: merged_word = store_data;
         default: merged_word = line_word;
      endcase
   end

endmodule

// File: rtl/data_cache.sv
// Direct-mapped write-back/write-allocate D-cache; hits are zero-latency, misses stall via BUSYWAIT
// while block memory requests are held until MEM_BUSYWAIT falls. Optional DCACHE_MISALIGN_CHECK_EN.
module data_cache
   import mem_pkg::*;
#(
   parameter int INDEX_BITS = 3
)
(
   input  logic                CLK,
   input  logic                RESET_N,
   input  logic [3:0]          READ_WRITE,
   input  logic [31:0]         ADDRESS,
   input  logic [31:0]         WRITE_DATA,
   output logic [31:0]         READ_DATA,
   output logic                BUSYWAIT,
   output logic                MEM_READ,
   output logic                MEM_WRITE,
   output logic [27:0]         MEM_ADDRESS,
   output logic [BLOCK_W-1:0]  MEM_WRITEDATA,
   input  logic [BLOCK_W-1:0]  MEM_READDATA,
   input  logic                MEM_BUSYWAIT
`ifdef DCACHE_MISALIGN_CHECK_EN
   ,
   output logic                MISALIGNED
`endif
);

   localparam int LINES = 1 << INDEX_BITS;
   localparam int TAG_W = 32 - 4 - INDEX_BITS;

   logic [BLOCK_W-1:0]    line_data [LINES];
   logic [TAG_W-1:0]      line_tag  [LINES];
   logic [LINES-1:0]      line_valid;
   logic [LINES-1:0]      line_dirty;
   logic [BLOCK_W-1:0]    fill_buf;

   dc_state_t             state_q, state_d;
   logic                  mem_read_d, mem_write_d;
   logic [27:0]           mem_addr_d;
   logic [BLOCK_W-1:0]    mem_wdata_d;

   logic [TAG_W-1:0]      addr_tag;
   logic [INDEX_BITS-1:0] addr_idx;
   logic [WORD_OFF_W-1:0] word_sel;
   logic                  misaligned;
   logic                  access;
   logic                  hit;
   logic                  in_idle;
   logic                  store_cmd;
   logic [31:0]           cur_word;
   logic [31:0]           load_data;
   logic [31:0]           merged_word;

   assign addr_tag  = ADDRESS[31:4+INDEX_BITS];
   assign addr_idx  = ADDRESS[3+INDEX_BITS:4];
   assign word_sel  = ADDRESS[3:2];
   assign store_cmd = is_store(READ_WRITE);

`ifdef DCACHE_MISALIGN_CHECK_EN
   logic half_cmd, word_cmd;
   assign half_cmd   = (READ_WRITE == MEM_LH) || (READ_WRITE == MEM_LHU) || (READ_WRITE == MEM_SH);
   assign word_cmd   = (READ_WRITE == MEM_LW) || (READ_WRITE == MEM_SW);
   assign misaligned = RESET_N && READ_WRITE[3] &&
                       ((half_cmd && ADDRESS[0]) || (word_cmd && (ADDRESS[1:0] != 2'b00)));
   assign MISALIGNED = misaligned;
`else
   assign misaligned = 1'b0;
`endif

   // Reset gates the request so the pipeline sees no stall while it is held in reset.
   assign access   = READ_WRITE[3] && RESET_N && !misaligned;
   assign in_idle  = (state_q == ST_IDLE);
   assign hit      = access && line_valid[addr_idx] && (line_tag[addr_idx] == addr_tag);
   assign cur_word = line_data[addr_idx][{word_sel, 5'b00000} +: 32];

   load_store_align u_align (
      .cmd         (READ_WRITE),
      .byte_off    (ADDRESS[1:0]),
      .line_word   (cur_word),
      .store_data  (WRITE_DATA),
      .load_data   (load_data),
      .merged_word (merged_word)
   );

   assign READ_DATA = (in_idle && hit && !store_cmd) ? load_data : '0;
   assign BUSYWAIT  = !in_idle || (access && !hit);

   always_comb begin
      state_d     = state_q;
      mem_read_d  = 1'b0;
      mem_write_d = 1'b0;
      mem_addr_d  = '0;
      mem_wdata_d = '0;

      unique case (state_q)
         ST_IDLE: begin
            if (access && !hit)
               state_d = (line_valid[addr_idx] && line_dirty[addr_idx]) ? ST_WRITE_BACK : ST_FETCH;
         end
         ST_WRITE_BACK: if (!MEM_BUSYWAIT) state_d = ST_FETCH;
         ST_FETCH:      if (!MEM_BUSYWAIT) state_d = ST_UPDATE;
         default:       state_d = ST_IDLE;
      endcase

      // Requests are decoded from the next state and registered, so they are glitch-free.
      case (state_d)
         ST_WRITE_BACK: begin
            mem_write_d = 1'b1;
            mem_addr_d  = {line_tag[addr_idx], addr_idx};
            mem_wdata_d = line_data[addr_idx];
         end
         ST_FETCH: begin
            mem_read_d = 1'b1;
            mem_addr_d = {addr_tag, addr_idx};
         end
         default: ;
      endcase
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q       <= ST_IDLE;
         MEM_READ      <= 1'b0;
         MEM_WRITE     <= 1'b0;
         MEM_ADDRESS   <= '0;
         MEM_WRITEDATA <= '0;
      end else begin
         state_q       <= state_d;
         MEM_READ      <= mem_read_d;
         MEM_WRITE     <= mem_write_d;
         MEM_ADDRESS   <= mem_addr_d;
         MEM_WRITEDATA <= mem_wdata_d;
      end
   end

   // The fetched block is captured as the memory releases it, so UPDATE does not
   // depend on the memory still driving it.
   always_ff @(posedge CLK) begin
      if (state_q == ST_FETCH && !MEM_BUSYWAIT)
         fill_buf <= MEM_READDATA;
   end

   always_ff @(posedge CLK) begin
      if (state_q == ST_UPDATE) begin
         line_data[addr_idx] <= fill_buf;
         line_tag[addr_idx]  <= addr_tag;
      end else if (in_idle && hit && store_cmd) begin
         line_data[addr_idx][{word_sel, 5'b00000} +: 32] <= merged_word;
      end
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         line_valid <= '0;
         line_dirty <= '0;
      end else if (state_q == ST_UPDATE) begin
         line_valid[addr_idx] <= 1'b1;
         line_dirty[addr_idx] <= 1'b0;
      end else if (in_idle && hit && store_cmd) begin
         line_dirty[addr_idx] <= 1'b1;
      end
   end

endmodule

// File: tb/tb_data_cache.sv
// Bench for data_cache: directed vector table, reset-mid-miss sequence, then random
// accesses checked against a flat-memory reference with a tag/dirty occupancy model.
`timescale 1ns/1ps
module tb_data_cache;

   localparam int LAT = 3;
   localparam logic [3:0] LB = 4'b1000, LH = 4'b1001, LW = 4'b1010, SB = 4'b1011;
   localparam logic [3:0] LBU = 4'b1100, LHU = 4'b1101, SH = 4'b1110, SW = 4'b1111;

   logic         CLK = 1'b0;
   logic         RESET_N;
   logic [3:0]   READ_WRITE;
   logic [31:0]  ADDRESS, WRITE_DATA, READ_DATA;
   logic         BUSYWAIT, MEM_READ, MEM_WRITE;
   logic [27:0]  MEM_ADDRESS;
   logic [127:0] MEM_WRITEDATA;
   logic [127:0] MEM_READDATA = '0;
   logic         MEM_BUSYWAIT;
`ifdef DCACHE_MISALIGN_CHECK_EN
   logic         MISALIGNED;
`endif

   int n_cmp = 0;
   int n_bad = 0;

   always #5 CLK = ~CLK;

   data_cache #(.INDEX_BITS(3)) dut (
      .CLK           (CLK),
      .RESET_N       (RESET_N),
      .READ_WRITE    (READ_WRITE),
      .ADDRESS       (ADDRESS),
      .WRITE_DATA    (WRITE_DATA),
      .READ_DATA     (READ_DATA),
      .BUSYWAIT      (BUSYWAIT),
      .MEM_READ      (MEM_READ),
      .MEM_WRITE     (MEM_WRITE),
      .MEM_ADDRESS   (MEM_ADDRESS),
      .MEM_WRITEDATA (MEM_WRITEDATA),
      .MEM_READDATA  (MEM_READDATA),
      .MEM_BUSYWAIT  (MEM_BUSYWAIT)
`ifdef DCACHE_MISALIGN_CHECK_EN
      ,
      .MISALIGNED    (MISALIGNED)
`endif
   );

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // ---------------- block memory with fixed latency ----------------
   logic [127:0] mem [bit [27:0]];
   int cnt = 0;

   function automatic logic [31:0] init_word(input logic [29:0] wa);
      return ({wa, 2'b00} * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
   endfunction

   function automatic logic [127:0] blk_read(input logic [27:0] a);
      logic [127:0] b;
      if (mem.exists(a)) return mem[a];
      for (int i = 0; i < 4; i++) b[32*i +: 32] = init_word({a, i[1:0]});
      return b;
   endfunction

   assign MEM_BUSYWAIT = (MEM_READ || MEM_WRITE) && (cnt != LAT - 1);

   always @(posedge CLK) begin
      if (MEM_READ) MEM_READDATA <= blk_read(MEM_ADDRESS);
      if (MEM_READ || MEM_WRITE) begin
         if (cnt == LAT - 1) begin
            cnt <= 0;
            if (MEM_WRITE) mem[MEM_ADDRESS] = MEM_WRITEDATA;
         end else begin
            cnt <= cnt + 1;
         end
      end else begin
         cnt <= 0;
      end
   end

   // ---------------- reference model ----------------
   logic [31:0] arch [bit [29:0]];
   bit          m_valid [8];
   bit          m_dirty [8];
   logic [24:0] m_tag   [8];

   function automatic logic [31:0] ref_word(input logic [29:0] wa);
      logic [127:0] b;
      if (arch.exists(wa)) return arch[wa];
      b = blk_read(wa[29:2]);
      return b[{wa[1:0], 5'b00000} +: 32];
   endfunction

   function automatic logic [127:0] arch_blk(input logic [27:0] a);
      logic [127:0] b;
      for (int i = 0; i < 4; i++) b[32*i +: 32] = ref_word({a, i[1:0]});
      return b;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 8; i++) begin
         m_valid[i] = 1'b0;
         m_dirty[i] = 1'b0;
      end
      arch.delete();
   endtask

   task automatic model_access(input logic [3:0] cmd, input logic [31:0] addr, input logic [31:0] wdata,
                               output logic [31:0] exp_rd, output int exp_stall,
                               output bit wb, output logic [27:0] wb_addr);
      int unsigned idx, size;
      logic [31:0] ea, w;
      logic [7:0]  b;
      logic [15:0] h;
      idx = addr[6:4];
      exp_rd = '0; exp_stall = 0; wb = 1'b0; wb_addr = '0;
      if (!cmd[3]) return;
      if (!(m_valid[idx] && m_tag[idx] == addr[31:7])) begin
         exp_stall = LAT + 2;
         if (m_valid[idx] && m_dirty[idx]) begin
            wb = 1'b1;
            wb_addr = {m_tag[idx], addr[6:4]};
            exp_stall += LAT;
         end
         m_valid[idx] = 1'b1;
         m_dirty[idx] = 1'b0;
         m_tag[idx]   = addr[31:7];
      end
      size = (cmd == LB || cmd == LBU || cmd == SB) ? 1 : (cmd == LH || cmd == LHU || cmd == SH) ? 2 : 4;
      ea = addr & ~(size - 1);
      w  = ref_word(ea[31:2]);
      b  = w[{ea[1:0], 3'b000} +: 8];
      h  = w[{ea[1], 4'b0000} +: 16];
      case (cmd)
         LB:  exp_rd = {{24{b[7]}}, b};
         LBU: exp_rd = {24'b0, b};
         LH:  exp_rd = {{16{h[15]}}, h};
         LHU: exp_rd = {16'b0, h};
         LW:  exp_rd = w;
         default: begin
            for (int k = 0; k < int'(size); k++) w[(int'(ea[1:0]) + k) * 8 +: 8] = wdata[k*8 +: 8];
            arch[ea[31:2]] = w;
            m_dirty[idx] = 1'b1;
         end
      endcase
   endtask

   // ---------------- write-back monitor ----------------
   logic [27:0] exp_wb_addr = '0;
   int          wb_seen = 0;

   always @(negedge CLK) begin
      if (RESET_N && MEM_WRITE && cnt == LAT - 1) begin
         wb_seen++;
         check("wb_addr", {100'b0, MEM_ADDRESS}, {100'b0, exp_wb_addr});
         check("wb_data", MEM_WRITEDATA, arch_blk(MEM_ADDRESS));
      end
   end

   // ---------------- driver ----------------
   task automatic do_access(input logic [3:0] cmd, input logic [31:0] addr, input logic [31:0] wdata,
                            output logic [31:0] rd, output int stall, output logic [27:0] faddr);
      bit fseen;
      @(negedge CLK);
      READ_WRITE = cmd; ADDRESS = addr; WRITE_DATA = wdata;
      #1;
      stall = 0; fseen = 1'b0; faddr = '0;
      while (BUSYWAIT && stall < 100) begin
         @(negedge CLK); #1;
         stall++;
         if (MEM_READ && !fseen) begin
            fseen = 1'b1;
            faddr = MEM_ADDRESS;
         end
      end
      rd = READ_DATA;
      @(posedge CLK); #1;
      READ_WRITE = 4'b0000;
   endtask

   // One access: model prediction, DUT run, checks against `use_exp` table values or the model.
   task automatic run_one(input string tag, input logic [3:0] cmd, input logic [31:0] addr,
                          input logic [31:0] wdata, input bit use_tbl,
                          input logic [31:0] tbl_rd, input int tbl_stall);
      logic [31:0] m_rd, rd;
      int          m_stall, stall, wb0;
      bit          wb;
      logic [27:0] wb_a, faddr;
      model_access(cmd, addr, wdata, m_rd, m_stall, wb, wb_a);
      if (use_tbl) begin
         m_rd = tbl_rd;
         m_stall = tbl_stall;
      end
      exp_wb_addr = wb_a;
      wb0 = wb_seen;
      do_access(cmd, addr, wdata, rd, stall, faddr);
      check({tag, "_rdata"}, {96'b0, rd}, {96'b0, m_rd});
      check({tag, "_stall"}, 128'(stall), 128'(m_stall));
      check({tag, "_wbcount"}, 128'(wb_seen - wb0), 128'(wb ? 1 : 0));
      if (m_stall > 0) check({tag, "_fetch_addr"}, {100'b0, faddr}, {100'b0, addr[31:4]});
   endtask

   typedef struct {
      logic [3:0]  cmd;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_rd;
      int          exp_stall;
   } vec_t;

   vec_t tbl [11];

   initial begin
      logic [31:0] w4;
      logic [3:0]  cmds [8];
      bit          seen;
      logic [31:0] a, rd;
      int          st;
      logic [27:0] fa;

      cmds = '{LB, LH, LW, SB, LBU, LHU, SH, SW};
      w4 = init_word(30'd4);
      tbl[0]  = '{LW,  32'h10, 32'h0,    w4,                         LAT + 2};
      tbl[1]  = '{SB,  32'h13, 32'hA5,   32'h0,                      0};
      tbl[2]  = '{LB,  32'h13, 32'h0,    32'hFFFF_FFA5,              0};
      tbl[3]  = '{LBU, 32'h13, 32'h0,    32'h0000_00A5,              0};
      tbl[4]  = '{SH,  32'h12, 32'h8001, 32'h0,                      0};
      tbl[5]  = '{LH,  32'h12, 32'h0,    32'hFFFF_8001,              0};
      tbl[6]  = '{LHU, 32'h12, 32'h0,    32'h0000_8001,              0};
      tbl[7]  = '{LW,  32'h10, 32'h0,    {16'h8001, w4[15:0]},       0};
      tbl[8]  = '{LW,  32'h90, 32'h0,    init_word(30'h24),          2 * LAT + 2};
      tbl[9]  = '{LW,  32'h10, 32'h0,    {16'h8001, w4[15:0]},       LAT + 2};
      tbl[10] = '{SW,  32'h20, 32'h1234_5678, 32'h0,                 LAT + 2};

      RESET_N = 1'b0; READ_WRITE = LW; ADDRESS = 32'h10; WRITE_DATA = '0;
      model_reset();
      #12;
      check("rst_busywait", {127'b0, BUSYWAIT}, 128'd0);
      check("rst_read_data", {96'b0, READ_DATA}, 128'd0);
      check("rst_mem_req", {126'b0, MEM_READ, MEM_WRITE}, 128'd0);
      check("rst_mem_addr", {100'b0, MEM_ADDRESS}, 128'd0);
      check("rst_mem_wdata", MEM_WRITEDATA, 128'd0);
      READ_WRITE = 4'b0000;
      @(negedge CLK); RESET_N = 1'b1;

      for (int i = 0; i < 11; i++)
         run_one($sformatf("tbl%0d", i), tbl[i].cmd, tbl[i].addr, tbl[i].wdata, 1'b1,
                 tbl[i].exp_rd, tbl[i].exp_stall);

`ifdef DCACHE_MISALIGN_CHECK_EN
      @(negedge CLK);
      READ_WRITE = LW; ADDRESS = 32'h12; #1;
      check("mis_flag", {127'b0, MISALIGNED}, 128'd1);
      check("mis_busywait", {127'b0, BUSYWAIT}, 128'd0);
      check("mis_read_data", {96'b0, READ_DATA}, 128'd0);
      @(posedge CLK); #1; READ_WRITE = 4'b0000;
      run_one("mis_after", LW, 32'h10, 32'h0, 1'b1, {16'h8001, w4[15:0]}, 0);
`endif

      // Reset while a clean miss is in FETCH; dirty line at index 2 must be lost.
      @(negedge CLK);
      READ_WRITE = LW; ADDRESS = 32'h110; #1;
      seen = 1'b0;
      for (int c = 0; c < 20 && !seen; c++) begin
         @(negedge CLK); #1;
         if (MEM_READ) seen = 1'b1;
      end
      check("mid_fetch_seen", {127'b0, seen}, 128'd1);
      check("mid_fetch_addr", {100'b0, MEM_ADDRESS}, 128'h11);
      #2 RESET_N = 1'b0;
      #1;
      check("mid_rst_mem_read", {127'b0, MEM_READ}, 128'd0);
      check("mid_rst_busywait", {127'b0, BUSYWAIT}, 128'd0);
      check("mid_rst_mem_addr", {100'b0, MEM_ADDRESS}, 128'd0);
      READ_WRITE = 4'b0000;
      model_reset();
      @(negedge CLK); RESET_N = 1'b1;

      run_one("post_rst_lw10", LW, 32'h10, 32'h0, 1'b1, {16'h8001, w4[15:0]}, LAT + 2);
      run_one("post_rst_lw20", LW, 32'h20, 32'h0, 1'b1, init_word(30'd8), LAT + 2);

      for (int n = 0; n < 300; n++) begin
         logic [3:0] cmd;
         cmd = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 7)) : cmds[$urandom_range(0, 7)];
         a = {23'b0, 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 4'($urandom)};
`ifdef DCACHE_MISALIGN_CHECK_EN
         if (cmd == LW || cmd == SW) a[1:0] = 2'b00;
         if (cmd == LH || cmd == LHU || cmd == SH) a[0] = 1'b0;
`endif
         run_one($sformatf("rnd%0d", n), cmd, a, $urandom, 1'b0, 32'h0, 0);
      end

      do_access(4'b0000, 32'h10, 32'h0, rd, st, fa);
      check("idle_read_data", {96'b0, rd}, 128'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
      $fatal(1);
   end

endmodule
